dir_input_ctrl: RTL and testbench

Direction command scheduler for the snake game. It takes the four debounced button levels, converts presses into direction commands and arbitrates simultaneous presses. It validates each command against the current heading, rejecting reversal and repeat commands. Accepted commands are buffered in a 2-entry FIFO, and exactly one command is applied per game-step tick. It sits between the four button debouncers and the snake movement engine.

---
 rtl/dir_input_ctrl.sv | 119 +++++++++++
 tb/tb_dir_input_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/dir_input_ctrl.sv
// Direction command scheduler: edge-detects four buttons, arbitrates and validates presses
// against the current heading, buffers them in a 2-entry FIFO and applies one per tick.
module dir_input_ctrl #(
  parameter logic [1:0] RESET_DIR = 2'b00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       tick,
  input  logic       clear,
  output logic [1:0] dir_out,
  output logic [1:0] q_count,
  output logic       reject,
  output logic       drop
);

  localparam logic [1:0] DirRight = 2'b00;
  localparam logic [1:0] DirDown  = 2'b01;
  localparam logic [1:0] DirLeft  = 2'b10;
  localparam logic [1:0] DirUp    = 2'b11;

  // Button order in history/press vectors: {up, down, left, right}
  logic [3:0] btn;
  logic [3:0] prev_q, prev_d;
  logic [3:0] press;

  logic [1:0] dir_q, dir_d;
  logic [1:0] cnt_q, cnt_d;
  logic       hd_q, hd_d;
  logic [1:0] mem_q [2];
  logic [1:0] mem_d [2];
  logic       reject_q, reject_d;
  logic       drop_q, drop_d;

  logic       have_cmd;
  logic [1:0] cmd;
  logic [1:0] ref_dir;
  logic       tail_idx;
  logic       wr_idx;
  logic       valid;
  logic       push;
  logic       pop;

  assign btn   = {btn_up, btn_down, btn_left, btn_right};
  assign press = btn & ~prev_q;

  always_comb begin
    have_cmd = 1'b1;
    cmd      = DirRight;
    if (press[3])      cmd = DirUp;
    else if (press[2]) cmd = DirDown;
    else if (press[1]) cmd = DirLeft;
    else if (press[0]) cmd = DirRight;
    else               have_cmd = 1'b0;
  end

  // Tail is the newest entry: hd for one entry, the other slot for two.
  assign tail_idx = (cnt_q == 2'd2) ? ~hd_q : hd_q;
  assign ref_dir  = (cnt_q != 2'd0) ? mem_q[tail_idx] : dir_q;
  assign valid    = (cmd != ref_dir) && (cmd != (ref_dir ^ 2'b10));
  assign pop      = tick && (cnt_q != 2'd0);
  assign push     = have_cmd && valid && ((cnt_q != 2'd2) || tick);
  // With a full queue the write lands on the head slot, which the same-cycle pop vacates.
  assign wr_idx   = hd_q ^ cnt_q[0];

  always_comb begin
    prev_d   = btn;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    hd_d     = hd_q;
    mem_d    = mem_q;
    reject_d = 1'b0;
    drop_d   = 1'b0;
    if (clear) begin
      dir_d = RESET_DIR;
      cnt_d = 2'd0;
      hd_d  = 1'b0;
    end else begin
      if (pop) begin
        dir_d = mem_q[hd_q];
        hd_d  = ~hd_q;
      end
      if (push) mem_d[wr_idx] = cmd;
      cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
      reject_d = have_cmd && !valid;
      drop_d   = have_cmd && valid && !push;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q   <= 4'b0000;
      dir_q    <= RESET_DIR;
      cnt_q    <= 2'd0;
      hd_q     <= 1'b0;
      mem_q[0] <= 2'b00;
      mem_q[1] <= 2'b00;
      reject_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      hd_q     <= hd_d;
      mem_q    <= mem_d;
      reject_q <= reject_d;
      drop_q   <= drop_d;
    end
  end

  assign dir_out = dir_q;
  assign q_count = cnt_q;
  assign reject  = reject_q;
  assign drop    = drop_q;

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Directed bench for dir_input_ctrl: hand-computed heading/queue/pulse values per cycle.
module tb_dir_input_ctrl;

  logic       clk = 1'b0;
  logic       reset, btn_up, btn_down, btn_left, btn_right, tick, clear;
  logic [1:0] dir_out, q_count;
  logic       reject, drop;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  dir_input_ctrl #(.RESET_DIR(2'b00)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .tick      (tick),
    .clear     (clear),
    .dir_out   (dir_out),
    .q_count   (q_count),
    .reject    (reject),
    .drop      (drop)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [1:0] d, input logic [1:0] c,
                              input logic r, input logic dr);
    check_eq({tag, ".dir"}, {6'd0, dir_out}, {6'd0, d});
    check_eq({tag, ".cnt"}, {6'd0, q_count}, {6'd0, c});
    check_eq({tag, ".rej"}, {7'd0, reject}, {7'd0, r});
    check_eq({tag, ".drop"}, {7'd0, drop}, {7'd0, dr});
  endtask

  initial begin
    reset = 1'b1; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; tick = 0; clear = 0;
    step(); step();
    expect_state("reset", 2'b00, 2'd0, 0, 0);
    reset = 1'b0;

    // Down press queues, tick applies it
    btn_down = 1; step();            expect_state("t1_push", 2'b00, 2'd1, 0, 0);
    btn_down = 0; tick = 1; step();  expect_state("t1_pop", 2'b01, 2'd0, 0, 0);
    tick = 0; clear = 1; step();     expect_state("t1_clr", 2'b00, 2'd0, 0, 0);
    clear = 0;

    // Reversal and repeat rejected; empty tick holds heading
    btn_left = 1; step();            expect_state("t2_rev", 2'b00, 2'd0, 1, 0);
    btn_left = 0; step();            expect_state("t2_idle", 2'b00, 2'd0, 0, 0);
    btn_right = 1; step();           expect_state("t2_rep", 2'b00, 2'd0, 1, 0);
    btn_right = 0; tick = 1; step(); expect_state("t2_tick", 2'b00, 2'd0, 0, 0);
    tick = 0;

    // Up then left (validated against tail up)
    btn_up = 1; step();              expect_state("t3_up", 2'b00, 2'd1, 0, 0);
    btn_up = 0; btn_left = 1; step(); expect_state("t3_left", 2'b00, 2'd2, 0, 0);
    btn_left = 0; step();

    // Full queue: drop without tick, accept with tick
    btn_down = 1; step();            expect_state("t4_drop", 2'b00, 2'd2, 0, 1);
    btn_down = 0; step();            expect_state("t4_idle", 2'b00, 2'd2, 0, 0);
    btn_down = 1; tick = 1; step();  expect_state("t4_swap", 2'b11, 2'd2, 0, 0);
    btn_down = 0; step();            expect_state("t4_pop1", 2'b10, 2'd1, 0, 0);
    step();                          expect_state("t4_pop2", 2'b01, 2'd0, 0, 0);
    tick = 0;

    // Simultaneous up+right from heading down: up wins and is a reversal
    btn_up = 1; btn_right = 1; step(); expect_state("t5_arb", 2'b01, 2'd0, 1, 0);
    btn_up = 0; step();              expect_state("t5_hold", 2'b01, 2'd0, 0, 0);
    step();                          expect_state("t5_hold2", 2'b01, 2'd0, 0, 0);
    btn_right = 0;

    // Build dir=up with two queued, then clear with press and tick
    btn_left = 1; step();            expect_state("t6_a", 2'b01, 2'd1, 0, 0);
    btn_left = 0; btn_up = 1; step(); expect_state("t6_b", 2'b01, 2'd2, 0, 0);
    btn_up = 0; tick = 1; step();    expect_state("t6_c", 2'b10, 2'd1, 0, 0);
    tick = 0; btn_right = 1; step(); expect_state("t6_d", 2'b10, 2'd2, 0, 0);
    btn_right = 0; tick = 1; step(); expect_state("t6_e", 2'b11, 2'd1, 0, 0);
    tick = 0; btn_up = 1; step();    expect_state("t6_f", 2'b11, 2'd2, 0, 0);
    btn_up = 0;
    clear = 1; btn_down = 1; tick = 1; step(); expect_state("t6_clr", 2'b00, 2'd0, 0, 0);
    clear = 0; tick = 0; step();     expect_state("t6_held", 2'b00, 2'd0, 0, 0);
    btn_down = 0; step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
